// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM test sequencer.
// Holds the one-hot state encoding, the ASCII constants used in the UART
// result record, and a nibble-to-hex-ASCII helper.
package sram_seq_pkg;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StArm    = 6'b000010,
    StRun    = 6'b000100,
    StLatch  = 6'b001000,
    StReport = 6'b010000,
    StFault  = 6'b100000
  } state_e;

  localparam logic [7:0] AsciiP  = 8'h50;
  localparam logic [7:0] AsciiF  = 8'h46;
  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  // Record layout: status letter, 8 hex digits, CR, LF.
  localparam logic [3:0] LastByteIdx = 4'd10;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    // 'A' - 10 = 0x37
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/sram_seq_uart_tx.sv
// Minimal 8N1 UART transmitter, LSB first.
// Ports:
//   SRAM_sys_clk, SRAM_rst_n : clock, asynchronous active-low reset
//   data, valid, ready       : byte handshake; a byte is taken when valid & ready
//   txd                      : serial output, idle high
// ready returns high only once the stop bit of the current byte has completed.
module sram_seq_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       SRAM_sys_clk,
  input  logic       SRAM_rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [9:0]      shift_q;
  logic [3:0]      bits_q;
  logic [DivW-1:0] div_q;

  always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
    if (!SRAM_rst_n) begin
      shift_q <= '1;
      bits_q  <= '0;
      div_q   <= '0;
    end else if (bits_q == 4'd0) begin
      if (valid) begin
        shift_q <= {1'b1, data, 1'b0};
        bits_q  <= 4'd10;
        div_q   <= '0;
      end
    end else if (div_q == DivW'(CLKS_PER_BIT - 1)) begin
      div_q   <= '0;
      // Shift in ones so the line rests high once the frame is out.
      shift_q <= {1'b1, shift_q[9:1]};
      bits_q  <= bits_q - 4'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign ready = (bits_q == 4'd0);
  assign txd   = shift_q[0];

endmodule

// File: rtl/sram_test_sequencer.sv
// Control stage in front of the SRAM pattern tester.
// Issues SRAM_start, waits for SRAM_end, captures SRAM_error, keeps saturating
// run/fail statistics and flags a hung tester with a terminal timeout.
// Ports:
//   SRAM_sys_clk, SRAM_rst_n : clock, asynchronous active-low reset
//   btn_go, auto_mode        : asynchronous operator inputs (2-FF synchronised)
//   SRAM_end, SRAM_error     : tester completion pulse and error count
//   SRAM_start               : run request to the tester
//   busy                     : run in progress
//   last_error               : error count of the last completed run
//   run_cnt, fail_cnt        : completed / failing run counters (saturating)
//   led_fail, fault          : sticky failure indicator, timeout flag
//   uart_txd                 : result record output, idle high
// Build option: define SRAM_SEQ_UART_EN to stream each result record over UART.
module sram_test_sequencer
  import sram_seq_pkg::*;
#(
  parameter int unsigned TO_CYCLES    = 4_000_000,
  parameter int unsigned TO_W         = 23,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic             SRAM_sys_clk,
  input  logic             SRAM_rst_n,
  input  logic             btn_go,
  input  logic             auto_mode,
  input  logic             SRAM_end,
  input  logic [31:0]      SRAM_error,
  output logic             SRAM_start,
  output logic             busy,
  output logic [31:0]      last_error,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             led_fail,
  output logic             fault,
  output logic             uart_txd
);

  state_e          state_q, state_d;
  logic [2:0]      go_sync_q;
  logic [1:0]      auto_sync_q;
  logic            go_edge, auto_on, to_hit, start_q, report_done;
  logic [TO_W-1:0] to_cnt_q;

  // Stages 0/1 synchronise, stage 2 remembers the previous level for edge detection.
  always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
    if (!SRAM_rst_n) begin
      go_sync_q   <= '0;
      auto_sync_q <= '0;
    end else begin
      go_sync_q   <= {go_sync_q[1:0], btn_go};
      auto_sync_q <= {auto_sync_q[0], auto_mode};
    end
  end

  assign go_edge = go_sync_q[1] & ~go_sync_q[2];
  assign auto_on = auto_sync_q[1];
  assign to_hit  = (to_cnt_q == TO_W'(TO_CYCLES - 1));

  // State register
  always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
    if (!SRAM_rst_n) state_q <= StIdle;
    else             state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go_edge || (auto_on && (run_cnt != '0))) state_d = StArm;
      StArm:   state_d = StRun;
      // Completion takes priority over a coincident timeout.
      StRun: begin
        if (SRAM_end)    state_d = StLatch;
        else if (to_hit) state_d = StFault;
      end
`ifdef SRAM_SEQ_UART_EN
      StLatch:  state_d = StReport;
      StReport: if (report_done) state_d = StIdle;
`else
      StLatch:  state_d = StIdle;
`endif
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the mask keeps a tester that is already back in idle during its
  // end pulse from seeing a stale start.
  always_comb begin
    busy       = (state_q == StArm) || (state_q == StRun);
    SRAM_start = start_q & ~SRAM_end;
  end

  always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
    if (!SRAM_rst_n) begin
      start_q    <= 1'b0;
      to_cnt_q   <= '0;
      last_error <= '0;
      run_cnt    <= '0;
      fail_cnt   <= '0;
      led_fail   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (state_q == StArm) begin
        start_q  <= 1'b1;
        to_cnt_q <= '0;
      end
      if (state_q == StRun) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
        if (SRAM_end) begin
          last_error <= SRAM_error;
          start_q    <= 1'b0;
        end else if (to_hit) begin
          start_q  <= 1'b0;
          fault    <= 1'b1;
          led_fail <= 1'b1;
        end
      end
      if (state_q == StLatch) begin
        if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
        if (last_error != 32'd0) begin
          led_fail <= 1'b1;
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef SRAM_SEQ_UART_EN
  logic [3:0]  byte_idx_q;
  logic        last_sent_q, tx_valid, tx_ready;
  logic [7:0]  tx_byte;
  logic [31:0] err_shift;

  assign tx_valid    = (state_q == StReport) && !last_sent_q;
  assign report_done = last_sent_q && tx_ready;
  // Bring the hex digit for byte 1..8 into the top nibble, MSB first.
  assign err_shift   = last_error << {byte_idx_q - 4'd1, 2'b00};

  always_comb begin
    tx_byte = AsciiLf;
    if (byte_idx_q == 4'd0)      tx_byte = (last_error == 32'd0) ? AsciiP : AsciiF;
    else if (byte_idx_q <= 4'd8) tx_byte = hex_ascii(err_shift[31:28]);
    else if (byte_idx_q == 4'd9) tx_byte = AsciiCr;
  end

  always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
    if (!SRAM_rst_n) begin
      byte_idx_q  <= '0;
      last_sent_q <= 1'b0;
    end else if (state_q == StLatch) begin
      byte_idx_q  <= '0;
      last_sent_q <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      if (byte_idx_q == LastByteIdx) last_sent_q <= 1'b1;
      else                           byte_idx_q  <= byte_idx_q + 4'd1;
    end
  end

  sram_seq_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .SRAM_sys_clk(SRAM_sys_clk),
    .SRAM_rst_n  (SRAM_rst_n),
    .data        (tx_byte),
    .valid       (tx_valid),
    .ready       (tx_ready),
    .txd         (uart_txd)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = ^CLKS_PER_BIT;
  assign report_done = 1'b0;
  assign uart_txd    = 1'b1;
`endif

endmodule

// File: tb/tb_sram_test_sequencer.sv
module tb_sram_test_sequencer;

  localparam int ClksPerBit = 4;
`ifdef SRAM_SEQ_UART_EN
  localparam int Gap = 520;
`else
  localparam int Gap = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n, btn_go, auto_mode, SRAM_end, SRAM_start, busy, led_fail, fault, uart_txd;
  logic [31:0] SRAM_error, last_error;
  logic [15:0] run_cnt, fail_cnt;

  logic        btn2, end2, start2, busy2, led_fail2, fault2, txd2;
  logic [31:0] err2, last_error2;
  logic [1:0]  run_cnt2, fail_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_test_sequencer #(
    .TO_CYCLES(200), .TO_W(8), .CNT_W(16), .CLKS_PER_BIT(ClksPerBit)
  ) dut (
    .SRAM_sys_clk(clk), .SRAM_rst_n(rst_n), .btn_go(btn_go), .auto_mode(auto_mode),
    .SRAM_end(SRAM_end), .SRAM_error(SRAM_error), .SRAM_start(SRAM_start), .busy(busy),
    .last_error(last_error), .run_cnt(run_cnt), .fail_cnt(fail_cnt), .led_fail(led_fail),
    .fault(fault), .uart_txd(uart_txd)
  );

  sram_test_sequencer #(
    .TO_CYCLES(200), .TO_W(8), .CNT_W(2), .CLKS_PER_BIT(ClksPerBit)
  ) dut2 (
    .SRAM_sys_clk(clk), .SRAM_rst_n(rst_n), .btn_go(btn2), .auto_mode(1'b0),
    .SRAM_end(end2), .SRAM_error(err2), .SRAM_start(start2), .busy(busy2),
    .last_error(last_error2), .run_cnt(run_cnt2), .fail_cnt(fail_cnt2), .led_fail(led_fail2),
    .fault(fault2), .uart_txd(txd2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural tester: m_len = 0 means hang; otherwise SRAM_end is high in the
  // cycle where the sequencer's timeout counter equals m_len.
  logic [31:0] exp_q[$];
  logic        m_active;
  int          m_cnt, m_len, launches;
  logic [31:0] m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (SRAM_start) begin
        m_active <= 1'b1;
        m_cnt    <= 1;
        launches <= launches + 1;
        exp_q.push_back(m_err);
      end
    end else if (SRAM_end) begin
      m_active <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign SRAM_end   = m_active && (m_len != 0) && (m_cnt == m_len);
  assign SRAM_error = SRAM_end ? m_err : 32'hDEAD_BEEF;

  // Scoreboard and end-cycle start mask.
  int          prev_run   = 0;
  logic        prev_fault = 1'b0;
  logic [31:0] sb_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_run   = 0;
      prev_fault = 1'b0;
    end else begin
      if (SRAM_end) check("start_masked_in_end", SRAM_start, 1'b0);
      if (int'(run_cnt) != prev_run) begin
        check("sb_entry_present", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          check("sb_last_error", last_error, sb_exp);
        end
        check("sb_run_step", run_cnt, prev_run + 1);
      end
      if (fault && !prev_fault && exp_q.size() > 0) sb_exp = exp_q.pop_front();
      prev_run   = int'(run_cnt);
      prev_fault = fault;
    end
  end

`ifdef SRAM_SEQ_UART_EN
  string       rx_str = "";
  int          rx_cnt = 0;
  logic        rx_busy = 1'b0;
  logic [7:0]  rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rx_busy) begin
      if (rst_n && uart_txd == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % ClksPerBit == ClksPerBit / 2) begin
        if (rx_cnt / ClksPerBit >= 1 && rx_cnt / ClksPerBit <= 8) begin
          rx_sh[rx_cnt / ClksPerBit - 1] = uart_txd;
        end else if (rx_cnt / ClksPerBit == 9) begin
          check("uart_stop_bit", uart_txd, 1'b1);
          rx_str  = $sformatf("%s%c", rx_str, rx_sh);
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic check_str(input string tag, input string obs, input string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_go();
    @(negedge clk) btn_go = 1'b1;
    repeat (3) @(negedge clk);
    btn_go = 1'b0;
  endtask

  task automatic wait_run_cnt(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(run_cnt) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, run_cnt, target);
  endtask

  // Returns right after the edge on which SRAM_start rises.
  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!SRAM_start && n < budget);
    check(tag, SRAM_start, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, SRAM_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_last_error"}, last_error, 32'd0);
    check({tag, "_run_cnt"}, run_cnt, 32'd0);
    check({tag, "_fail_cnt"}, fail_cnt, 32'd0);
    check({tag, "_led_fail"}, led_fail, 1'b0);
    check({tag, "_fault"}, fault, 1'b0);
    check({tag, "_uart_txd"}, uart_txd, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; btn_go = 1'b0; auto_mode = 1'b0;
    btn2 = 1'b0; end2 = 1'b0; err2 = 32'd0;
    m_len = 50; m_err = 32'd0; launches = 0;
    #2;
    check_reset_values("reset");
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(3);

    // 1: single passing run, 4-cycle go latency
    @(negedge clk) btn_go = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_3_cycles", SRAM_start, 1'b0);
    @(posedge clk);
    #1 check("latency_4_cycles", SRAM_start, 1'b1);
    check("busy_in_run", busy, 1'b1);
    @(negedge clk) btn_go = 1'b0;
    wait_run_cnt("t1_run_done", 1, 300);
    tick(Gap);
    check("t1_run_cnt", run_cnt, 32'd1);
    check("t1_fail_cnt", fail_cnt, 32'd0);
    check("t1_led_fail", led_fail, 1'b0);
    check("t1_single_launch", launches, 32'd1);
    check("t1_idle", busy, 1'b0);

    // 2: failing run
    m_err = 32'h0000_001F;
`ifdef SRAM_SEQ_UART_EN
    rx_str = "";
`endif
    pulse_go();
    wait_run_cnt("t2_run_done", 2, 300);
    check("t2_last_error", last_error, 32'h1F);
    check("t2_fail_cnt", fail_cnt, 32'd1);
    check("t2_led_fail", led_fail, 1'b1);
    tick(Gap);
`ifdef SRAM_SEQ_UART_EN
    check_str("t2_uart_record", rx_str, "F0000001F\r\n");
`else
    check("t2_uart_idle", uart_txd, 1'b1);
`endif

    // 3: auto re-arm, then stop after the current run
    m_err = 32'd0; m_len = 20;
    @(negedge clk) auto_mode = 1'b1;
    wait_run_cnt("t3_auto_reached_5", 5, 5 * (Gap + 60));
    begin
      int n = 0;
      while (!busy && n < Gap + 20) begin
        @(negedge clk);
        n++;
      end
      check("t3_next_run_started", busy, 1'b1);
    end
    auto_mode = 1'b0;
    tick(2 * Gap + 100);
    check("t3_run_cnt_stopped", run_cnt, 32'd6);
    check("t3_launches", launches, 32'd6);
    check("t3_fail_cnt", fail_cnt, 32'd1);
    check("t3_idle", busy, 1'b0);

    // 4b: end in the last allowed cycle completes normally
    m_len = 199; m_err = 32'hA5A5_0000;
    pulse_go();
    wait_run_cnt("t4b_run_done", 7, 400);
    check("t4b_no_fault", fault, 1'b0);
    check("t4b_last_error", last_error, 32'hA5A5_0000);
    check("t4b_fail_cnt", fail_cnt, 32'd2);
    tick(Gap);

    // 5: go during RUN (and REPORT) dropped
    m_len = 60; m_err = 32'd0;
    pulse_go();
    wait_start("t5_start", 20);
    tick(10);
    pulse_go();
    wait_run_cnt("t5_run_done", 8, 200);
`ifdef SRAM_SEQ_UART_EN
    pulse_go();
`endif
    tick(Gap);
    check("t5_no_extra_run", run_cnt, 32'd8);
    check("t5_launches", launches, 32'd8);
    check("t5_idle", busy, 1'b0);

    // 5b: asynchronous reset mid-run
    m_len = 0;
    pulse_go();
    wait_start("t5b_start", 20);
    tick(5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(3);

    // 4: hung tester -> fault exactly 200 RUN cycles after ARM
    pulse_go();
    wait_start("t4_start", 20);
    repeat (199) @(posedge clk);
    #1 check("t4_no_fault_before", fault, 1'b0);
    check("t4_start_held", SRAM_start, 1'b1);
    @(posedge clk);
    #1 check("t4_fault", fault, 1'b1);
    check("t4_start_dropped", SRAM_start, 1'b0);
    check("t4_led_fail", led_fail, 1'b1);
    check("t4_not_busy", busy, 1'b0);
    pulse_go();
    tick(20);
    check("t4_go_ignored_busy", busy, 1'b0);
    check("t4_go_ignored_start", SRAM_start, 1'b0);
    check("t4_fault_sticky", fault, 1'b1);

    // 6: saturation with 2-bit counters
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      @(negedge clk) btn2 = 1'b1;
      repeat (3) @(negedge clk);
      btn2 = 1'b0;
      while (!start2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t6_start", start2, 1'b1);
      tick(3);
      @(negedge clk) begin end2 = 1'b1; err2 = 32'(i + 1); end
      @(negedge clk) begin end2 = 1'b0; err2 = 32'd0; end
      tick(Gap);
    end
    check("t6_run_cnt_sat", run_cnt2, 32'd3);
    check("t6_fail_cnt_sat", fail_cnt2, 32'd3);
    check("t6_led_fail", led_fail2, 1'b1);
    check("t6_last_error", last_error2, 32'd5);
    check("t6_no_fault", fault2, 1'b0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed run still active expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
